// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 Set-2 decoder types: parser states, prefix/modifier codes, scan-code table.
// Pure declarations; no latency or backpressure of its own.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_LETTER = 2'd1,
        CLS_DIGIT  = 2'd2,
        CLS_FIXED  = 2'd3
    } key_class_e;

    // base = unshifted character, alt = uppercase letter or US shifted digit symbol
    typedef struct packed {
        key_class_e cls;
        logic [7:0] base;
        logic [7:0] alt;
    } lut_entry_t;

    function automatic lut_entry_t sc_lookup(input logic [7:0] code);
        lut_entry_t e;
        e = '{cls: CLS_NONE, base: 8'h00, alt: 8'h00};
        case (code)
            8'h1C: e = '{CLS_LETTER, 8'h61, 8'h41};
            8'h32: e = '{CLS_LETTER, 8'h62, 8'h42};
            8'h21: e = '{CLS_LETTER, 8'h63, 8'h43};
            8'h23: e = '{CLS_LETTER, 8'h64, 8'h44};
            8'h24: e = '{CLS_LETTER, 8'h65, 8'h45};
            8'h2B: e = '{CLS_LETTER, 8'h66, 8'h46};
            8'h34: e = '{CLS_LETTER, 8'h67, 8'h47};
            8'h33: e = '{CLS_LETTER, 8'h68, 8'h48};
            8'h43: e = '{CLS_LETTER, 8'h69, 8'h49};
            8'h3B: e = '{CLS_LETTER, 8'h6A, 8'h4A};
            8'h42: e = '{CLS_LETTER, 8'h6B, 8'h4B};
            8'h4B: e = '{CLS_LETTER, 8'h6C, 8'h4C};
            8'h3A: e = '{CLS_LETTER, 8'h6D, 8'h4D};
            8'h31: e = '{CLS_LETTER, 8'h6E, 8'h4E};
            8'h44: e = '{CLS_LETTER, 8'h6F, 8'h4F};
            8'h4D: e = '{CLS_LETTER, 8'h70, 8'h50};
            8'h15: e = '{CLS_LETTER, 8'h71, 8'h51};
            8'h2D: e = '{CLS_LETTER, 8'h72, 8'h52};
            8'h1B: e = '{CLS_LETTER, 8'h73, 8'h53};
            8'h2C: e = '{CLS_LETTER, 8'h74, 8'h54};
            8'h3C: e = '{CLS_LETTER, 8'h75, 8'h55};
            8'h2A: e = '{CLS_LETTER, 8'h76, 8'h56};
            8'h1D: e = '{CLS_LETTER, 8'h77, 8'h57};
            8'h22: e = '{CLS_LETTER, 8'h78, 8'h58};
            8'h35: e = '{CLS_LETTER, 8'h79, 8'h59};
            8'h1A: e = '{CLS_LETTER, 8'h7A, 8'h5A};
            8'h45: e = '{CLS_DIGIT,  8'h30, 8'h29};
            8'h16: e = '{CLS_DIGIT,  8'h31, 8'h21};
            8'h1E: e = '{CLS_DIGIT,  8'h32, 8'h40};
            8'h26: e = '{CLS_DIGIT,  8'h33, 8'h23};
            8'h25: e = '{CLS_DIGIT,  8'h34, 8'h24};
            8'h2E: e = '{CLS_DIGIT,  8'h35, 8'h25};
            8'h36: e = '{CLS_DIGIT,  8'h36, 8'h5E};
            8'h3D: e = '{CLS_DIGIT,  8'h37, 8'h26};
            8'h3E: e = '{CLS_DIGIT,  8'h38, 8'h2A};
            8'h46: e = '{CLS_DIGIT,  8'h39, 8'h28};
            8'h29: e = '{CLS_FIXED,  8'h20, 8'h20};
            8'h5A: e = '{CLS_FIXED,  8'h0D, 8'h0D};
            8'h66: e = '{CLS_FIXED,  8'h08, 8'h08};
            default: e = '{cls: CLS_NONE, base: 8'h00, alt: 8'h00};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational Set-2 make code to ASCII translation with Shift/Caps case rules.
// Zero latency; no flow control.
module ps2_ascii_lut
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       shift_i,
    input  logic       caps_i,
    output logic [7:0] ascii_o,
    output logic       mapped_o
);

    lut_entry_t entry;

    always_comb begin
        entry    = sc_lookup(code_i);
        ascii_o  = 8'h00;
        mapped_o = 1'b1;
        case (entry.cls)
            CLS_LETTER: ascii_o = (shift_i ^ caps_i) ? entry.alt : entry.base;
            CLS_DIGIT:  ascii_o = shift_i ? entry.alt : entry.base;
            CLS_FIXED:  ascii_o = entry.base;
            default:    mapped_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code parser with Shift/Caps tracking feeding an FWFT ASCII FIFO.
// Strobe in cycle N -> character at the head in N+1; no backpressure upstream, full FIFO drops and flags overflow.
module ps2_scancode_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    input  logic       rd_en,
    output logic [7:0] ascii_out,
    output logic       key_valid,
    output logic       fifo_full,
    output logic       overflow,
    output logic       shift_active,
    output logic       caps_lock,
    output logic [7:0] last_make_code
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    parse_state_e state_q, state_d;
    logic         lshift_q, lshift_d;
    logic         rshift_q, rshift_d;
    logic         caps_q, caps_d;
    logic [7:0]   last_make_q, last_make_d;
    logic         overflow_q, overflow_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic       make_vld;
    logic       brk_vld;
    logic       is_modifier;
    logic       wr_req;
    logic       do_wr;
    logic       do_rd;
    logic       full;
    logic [7:0] lut_ascii;
    logic       lut_mapped;

    // Translation uses the registered modifiers, i.e. the state before this byte.
    ps2_ascii_lut u_lut (
        .code_i   (ps2_key_data),
        .shift_i  (lshift_q | rshift_q),
        .caps_i   (caps_q),
        .ascii_o  (lut_ascii),
        .mapped_o (lut_mapped)
    );

    always_ff @(posedge inclock) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            last_make_q <= 8'h00;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            last_make_q <= last_make_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge inclock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= lut_ascii;
        end
    end

    always_comb begin
        state_d  = state_q;
        make_vld = 1'b0;
        brk_vld  = 1'b0;
        if (ps2_key_pressed) begin
            case (state_q)
                ST_IDLE: begin
                    if (ps2_key_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (ps2_key_data == SC_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        make_vld = 1'b1;
                    end
                end
                ST_EXT:  state_d = (ps2_key_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK: begin
                    brk_vld = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        last_make_d = last_make_q;
        is_modifier = (ps2_key_data == SC_LSHIFT) || (ps2_key_data == SC_RSHIFT) ||
                      (ps2_key_data == SC_CAPS);
        if (make_vld) begin
            last_make_d = ps2_key_data;
            if (ps2_key_data == SC_LSHIFT) lshift_d = 1'b1;
            if (ps2_key_data == SC_RSHIFT) rshift_d = 1'b1;
            if (ps2_key_data == SC_CAPS)   caps_d   = ~caps_q;
        end
        if (brk_vld) begin
            if (ps2_key_data == SC_LSHIFT) lshift_d = 1'b0;
            if (ps2_key_data == SC_RSHIFT) rshift_d = 1'b0;
        end
    end

    always_comb begin
        full       = (count_q == DEPTH_C);
        wr_req     = make_vld && !is_modifier && lut_mapped;
        do_rd      = rd_en && (count_q != '0);
        // A pop in the same cycle frees the slot, so a write at full still lands.
        do_wr      = wr_req && (!full || do_rd);
        overflow_d = overflow_q | (wr_req && !do_wr);
        wr_ptr_d   = do_wr ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = do_rd ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d    = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + CNT_ONE;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CNT_ONE;
        end
    end

    assign key_valid      = (count_q != '0);
    assign ascii_out      = key_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_full      = full;
    assign overflow       = overflow_q;
    assign shift_active   = lshift_q | rshift_q;
    assign caps_lock      = caps_q;
    assign last_make_code = last_make_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench: per-cycle vector table for parsing/case rules, hand sequences for overflow and mid-sequence reset.
module tb_ps2_scancode_decoder;

    logic       inclock;
    logic       resetn;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic       rd_en;
    logic [7:0] ascii_out;
    logic       key_valid;
    logic       fifo_full;
    logic       overflow;
    logic       shift_active;
    logic       caps_lock;
    logic [7:0] last_make_code;

    int n_tests;
    int n_fail;

    ps2_scancode_decoder #(.FIFO_DEPTH(8), .PTR_W(3)) dut (
        .inclock         (inclock),
        .resetn          (resetn),
        .ps2_key_data    (ps2_key_data),
        .ps2_key_pressed (ps2_key_pressed),
        .rd_en           (rd_en),
        .ascii_out       (ascii_out),
        .key_valid       (key_valid),
        .fifo_full       (fifo_full),
        .overflow        (overflow),
        .shift_active    (shift_active),
        .caps_lock       (caps_lock),
        .last_make_code  (last_make_code)
    );

    initial inclock = 1'b0;
    always #5 inclock = ~inclock;

    typedef struct {
        logic       pr;
        logic [7:0] dat;
        logic       rd;
        logic       rstn;
        logic       vld;
        logic [7:0] asc;
        logic       sh;
        logic       cp;
        logic       full;
        logic       ovf;
        logic [7:0] last;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic pr, input logic [7:0] dat, input logic rd, input logic rstn,
                       input logic vld, input logic [7:0] asc, input logic sh, input logic cp,
                       input logic full, input logic ovf, input logic [7:0] last);
        vec_t v;
        v = '{pr, dat, rd, rstn, vld, asc, sh, cp, full, ovf, last};
        vecs.push_back(v);
    endtask

    task automatic cyc(input logic pr, input logic [7:0] dat, input logic rd, input logic rstn);
        @(negedge inclock);
        ps2_key_pressed = pr;
        ps2_key_data    = dat;
        rd_en           = rd;
        resetn          = rstn;
        @(posedge inclock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {11'd0, key_valid, ascii_out, shift_active, caps_lock, fifo_full, overflow, last_make_code};
    endfunction

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        resetn          = 1'b0;
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        rd_en           = 1'b0;

        //   pr  dat    rd rstn  vld asc    sh cp fu ov last
        add(0, 8'h00, 0, 0,    0, 8'h00, 0, 0, 0, 0, 8'h00);  // reset
        add(1, 8'h1C, 0, 1,    1, 8'h61, 0, 0, 0, 0, 8'h1C);  // 'a' at N+1
        add(1, 8'hF0, 0, 1,    1, 8'h61, 0, 0, 0, 0, 8'h1C);
        add(1, 8'h1C, 0, 1,    1, 8'h61, 0, 0, 0, 0, 8'h1C);  // break writes nothing
        add(0, 8'h00, 1, 1,    0, 8'h00, 0, 0, 0, 0, 8'h1C);
        add(1, 8'h12, 0, 1,    0, 8'h00, 1, 0, 0, 0, 8'h12);  // left shift
        add(1, 8'h1C, 0, 1,    1, 8'h41, 1, 0, 0, 0, 8'h1C);
        add(1, 8'hF0, 0, 1,    1, 8'h41, 1, 0, 0, 0, 8'h1C);
        add(1, 8'h12, 0, 1,    1, 8'h41, 0, 0, 0, 0, 8'h1C);
        add(1, 8'h1C, 0, 1,    1, 8'h41, 0, 0, 0, 0, 8'h1C);
        add(0, 8'h00, 1, 1,    1, 8'h61, 0, 0, 0, 0, 8'h1C);
        add(0, 8'h00, 1, 1,    0, 8'h00, 0, 0, 0, 0, 8'h1C);
        add(1, 8'h58, 0, 1,    0, 8'h00, 0, 1, 0, 0, 8'h58);  // caps on
        add(1, 8'hF0, 0, 1,    0, 8'h00, 0, 1, 0, 0, 8'h58);
        add(1, 8'h58, 0, 1,    0, 8'h00, 0, 1, 0, 0, 8'h58);  // caps break ignored
        add(1, 8'h1C, 0, 1,    1, 8'h41, 0, 1, 0, 0, 8'h1C);
        add(1, 8'h16, 0, 1,    1, 8'h41, 0, 1, 0, 0, 8'h16);
        add(0, 8'h00, 1, 1,    1, 8'h31, 0, 1, 0, 0, 8'h16);  // caps leaves digits
        add(0, 8'h00, 1, 1,    0, 8'h00, 0, 1, 0, 0, 8'h16);
        add(1, 8'h12, 0, 1,    0, 8'h00, 1, 1, 0, 0, 8'h12);
        add(1, 8'h16, 0, 1,    1, 8'h21, 1, 1, 0, 0, 8'h16);  // '!'
        add(1, 8'h1C, 0, 1,    1, 8'h21, 1, 1, 0, 0, 8'h1C);
        add(0, 8'h00, 1, 1,    1, 8'h61, 1, 1, 0, 0, 8'h1C);  // shift XOR caps
        add(0, 8'h00, 1, 1,    0, 8'h00, 1, 1, 0, 0, 8'h1C);
        add(1, 8'hF0, 0, 1,    0, 8'h00, 1, 1, 0, 0, 8'h1C);
        add(1, 8'h12, 0, 1,    0, 8'h00, 0, 1, 0, 0, 8'h1C);
        add(1, 8'h58, 0, 1,    0, 8'h00, 0, 0, 0, 0, 8'h58);  // typematic toggles
        add(1, 8'h58, 0, 1,    0, 8'h00, 0, 1, 0, 0, 8'h58);
        add(1, 8'h58, 0, 1,    0, 8'h00, 0, 0, 0, 0, 8'h58);
        add(1, 8'hE0, 0, 1,    0, 8'h00, 0, 0, 0, 0, 8'h58);
        add(1, 8'h12, 0, 1,    0, 8'h00, 0, 0, 0, 0, 8'h58);  // fake shift ignored
        add(1, 8'hE0, 0, 1,    0, 8'h00, 0, 0, 0, 0, 8'h58);
        add(1, 8'h75, 0, 1,    0, 8'h00, 0, 0, 0, 0, 8'h58);
        add(1, 8'hE0, 0, 1,    0, 8'h00, 0, 0, 0, 0, 8'h58);
        add(1, 8'hF0, 0, 1,    0, 8'h00, 0, 0, 0, 0, 8'h58);
        add(1, 8'h75, 0, 1,    0, 8'h00, 0, 0, 0, 0, 8'h58);
        add(1, 8'h1C, 0, 1,    1, 8'h61, 0, 0, 0, 0, 8'h1C);  // parser back in IDLE
        add(0, 8'h00, 1, 1,    0, 8'h00, 0, 0, 0, 0, 8'h1C);
        add(1, 8'h05, 0, 1,    0, 8'h00, 0, 0, 0, 0, 8'h05);  // unmapped dropped
        add(1, 8'h5A, 0, 1,    1, 8'h0D, 0, 0, 0, 0, 8'h5A);
        add(0, 8'h00, 1, 1,    0, 8'h00, 0, 0, 0, 0, 8'h5A);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].pr, vecs[i].dat, vecs[i].rd, vecs[i].rstn);
            chk($sformatf("vec%0d", i), outs(),
                {11'd0, vecs[i].vld, vecs[i].asc, vecs[i].sh, vecs[i].cp,
                 vecs[i].full, vecs[i].ovf, vecs[i].last});
        end

        // Fill past capacity: full after 8, ninth is dropped and sets overflow.
        for (int i = 0; i < 9; i++) begin
            cyc(1, 8'h29, 0, 1);
            chk($sformatf("fill%0d", i), {29'd0, key_valid, fifo_full, overflow},
                {29'd0, 1'b1, (i >= 7), (i == 8)});
        end
        // Write with simultaneous pop at full: accepted, still full.
        cyc(1, 8'h29, 1, 1);
        chk("wr_rd_full", {29'd0, key_valid, fifo_full, overflow}, {29'd0, 3'b111});
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_head%0d", i), {24'd0, ascii_out}, 32'h20);
            cyc(0, 8'h00, 1, 1);
            chk($sformatf("drain_vld%0d", i), {31'd0, key_valid}, {31'd0, (i < 7)});
        end
        chk("drain_empty_ascii", {24'd0, ascii_out}, 32'h00);

        // Reset in the middle of an extended sequence with modifiers held.
        cyc(1, 8'h12, 0, 1);
        cyc(1, 8'h58, 0, 1);
        cyc(1, 8'hE0, 0, 1);
        chk("pre_rst_mods", {30'd0, shift_active, caps_lock}, {30'd0, 2'b11});
        cyc(0, 8'h00, 0, 0);
        chk("mid_rst_outs", outs(), 32'h0);
        cyc(1, 8'h1C, 0, 1);
        chk("post_rst_key", outs(), {11'd0, 1'b1, 8'h61, 4'b0000, 8'h1C});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
